// File: rtl/common_defs.sv
// Shared encodings for the core: SIMD phase values driven by the scheduler and
// the fetcher FSM states it reads back.
package common_defs;

  typedef enum logic [2:0] {
    SIMD_IDLE    = 3'd0,
    SIMD_FETCH   = 3'd1,
    SIMD_DECODE  = 3'd2,
    SIMD_REQUEST = 3'd3,
    SIMD_WAIT    = 3'd4,
    SIMD_EXECUTE = 3'd5,
    SIMD_UPDATE  = 3'd6,
    SIMD_DONE    = 3'd7
  } simd_phase_e;

  typedef enum logic [2:0] {
    FETCH_IDLE = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_DONE = 3'd2
  } fetch_state_e;

endpackage

// File: rtl/fetcher.sv
// Instruction fetcher: issues one program-memory read per SIMD_FETCH phase and
// latches the returned word. Optional FETCHER_LAST_HIT_EN adds a one-entry tag.
module fetcher
  import common_defs::*;
#(
  parameter int PROGRAM_ADDR_WIDTH = 8,
  parameter int INSTRUCTION_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [2:0]                    simd_state,
  input  logic [PROGRAM_ADDR_WIDTH-1:0] pc,
  output logic                          mem_read_valid,
  output logic [PROGRAM_ADDR_WIDTH-1:0] mem_read_address,
  input  logic                          mem_read_ready,
  input  logic [INSTRUCTION_WIDTH-1:0]  mem_read_data,
  output logic [2:0]                    fetcher_state,
  output logic [INSTRUCTION_WIDTH-1:0]  instruction
);

  fetch_state_e                  state_q, state_d;
  logic                          valid_d;
  logic [PROGRAM_ADDR_WIDTH-1:0] addr_d;
  logic [INSTRUCTION_WIDTH-1:0]  instr_d;
  logic                          hit;

`ifdef FETCHER_LAST_HIT_EN
  logic                          tag_valid_q, tag_valid_d;
  logic [PROGRAM_ADDR_WIDTH-1:0] tag_addr_q, tag_addr_d;

  assign hit = tag_valid_q && (tag_addr_q == pc);
`else
  assign hit = 1'b0;
`endif

  assign fetcher_state = state_q;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    valid_d = mem_read_valid;
    addr_d  = mem_read_address;
    instr_d = instruction;
`ifdef FETCHER_LAST_HIT_EN
    tag_valid_d = tag_valid_q;
    tag_addr_d  = tag_addr_q;
`endif
    if (enable) begin
      unique case (state_q)
        FETCH_IDLE: begin
          if (simd_state == SIMD_FETCH) begin
            if (hit) begin
              // Same address as the held word: skip memory, keep instruction.
              state_d = FETCH_DONE;
            end else begin
              valid_d = 1'b1;
              addr_d  = pc;
              state_d = FETCH_REQ;
            end
          end
        end
        FETCH_REQ: begin
          if (mem_read_ready) begin
            instr_d = mem_read_data;
            valid_d = 1'b0;
            state_d = FETCH_DONE;
`ifdef FETCHER_LAST_HIT_EN
            tag_valid_d = 1'b1;
            tag_addr_d  = mem_read_address;
`endif
          end
        end
        FETCH_DONE: begin
          if (simd_state == SIMD_DECODE) state_d = FETCH_IDLE;
        end
        default: begin
          state_d = FETCH_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= FETCH_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
    end else begin
      state_q          <= state_d;
      mem_read_valid   <= valid_d;
      mem_read_address <= addr_d;
      instruction      <= instr_d;
    end
  end

`ifdef FETCHER_LAST_HIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid_q <= 1'b0;
      tag_addr_q  <= '0;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_addr_q  <= tag_addr_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: expected instruction words are queued when the
// ready pulse is driven and popped when the FSM reaches FETCH_DONE.
module tb_fetcher;
  import common_defs::*;

  localparam int AW = 8;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [2:0]    simd_state;
  logic [AW-1:0] pc;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [IW-1:0] mem_read_data;
  logic [2:0]    fetcher_state;
  logic [IW-1:0] instruction;

  int n_cmp = 0;
  int n_err = 0;
  logic [IW-1:0] exp_q[$];

  fetcher #(.PROGRAM_ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(IW)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .simd_state       (simd_state),
    .pc               (pc),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the latched word against the oldest queued expectation.
  task automatic check_latch(input string tag);
    logic [IW-1:0] exp;
    check({tag, "_state"}, 64'(fetcher_state), 64'(FETCH_DONE));
    check({tag, "_valid"}, 64'(mem_read_valid), 64'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_instr"}, 64'(instruction), 64'(exp));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; simd_state = SIMD_IDLE; pc = '0;
    mem_read_ready = 1'b0; mem_read_data = '0;
    tick(); tick();
    check("rst_state", 64'(fetcher_state), 64'd0);
    check("rst_valid", 64'(mem_read_valid), 64'd0);
    check("rst_addr",  64'(mem_read_address), 64'd0);
    check("rst_instr", 64'(instruction), 64'd0);
    #2 rst = 1'b1;

    // Basic fetch with three wait cycles; pc moves during the request.
    enable = 1'b1; pc = 8'h05; simd_state = SIMD_FETCH;
    tick();
    check("basic_req_state", 64'(fetcher_state), 64'(FETCH_REQ));
    check("basic_req_valid", 64'(mem_read_valid), 64'd1);
    check("basic_req_addr",  64'(mem_read_address), 64'h05);
    simd_state = SIMD_WAIT; pc = 8'h77;
    tick(); tick();
    check("basic_hold_valid", 64'(mem_read_valid), 64'd1);
    check("basic_hold_addr",  64'(mem_read_address), 64'h05);
    check("basic_hold_instr", 64'(instruction), 64'd0);
    mem_read_ready = 1'b1; mem_read_data = 32'h1C0C2000; exp_q.push_back(32'h1C0C2000);
    tick();
    mem_read_ready = 1'b0; mem_read_data = 32'hFFFF_FFFF;
    check_latch("basic");

    // Stray ready in FETCH_DONE is ignored.
    mem_read_ready = 1'b1; mem_read_data = 32'h5555_5555;
    tick();
    mem_read_ready = 1'b0;
    check("done_stray_instr", 64'(instruction), 64'h1C0C2000);
    check("done_stray_state", 64'(fetcher_state), 64'(FETCH_DONE));

    // Return to idle on SIMD_DECODE.
    simd_state = SIMD_DECODE;
    tick();
    check("idle_state", 64'(fetcher_state), 64'(FETCH_IDLE));
    check("idle_instr", 64'(instruction), 64'h1C0C2000);
    check("idle_valid", 64'(mem_read_valid), 64'd0);

    // Zero-wait memory: valid high for exactly one cycle.
    pc = 8'h10; simd_state = SIMD_FETCH;
    tick();
    check("zw_valid_hi", 64'(mem_read_valid), 64'd1);
    simd_state = SIMD_WAIT;
    mem_read_ready = 1'b1; mem_read_data = 32'hA5A5_0001; exp_q.push_back(32'hA5A5_0001);
    tick();
    mem_read_ready = 1'b0;
    check_latch("zw");
    simd_state = SIMD_DECODE;
    tick();

    // Stall four cycles mid-request with ready held high.
    pc = 8'h20; simd_state = SIMD_FETCH;
    tick();
    simd_state = SIMD_WAIT;
    enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_state", 64'(fetcher_state), 64'(FETCH_REQ));
      check("stall_valid", 64'(mem_read_valid), 64'd1);
      check("stall_instr", 64'(instruction), 64'hA5A5_0001);
    end
    enable = 1'b1; exp_q.push_back(32'hDEAD_BEEF);
    tick();
    mem_read_ready = 1'b0;
    check_latch("stall");
    simd_state = SIMD_DECODE;
    tick();

    // Reset mid-request, then a late ready after release.
    pc = 8'h30; simd_state = SIMD_FETCH;
    tick();
    check("rmid_req_valid", 64'(mem_read_valid), 64'd1);
    simd_state = SIMD_IDLE;
    #2 rst = 1'b0;
    #1;
    check("rmid_async_valid", 64'(mem_read_valid), 64'd0);
    check("rmid_async_state", 64'(fetcher_state), 64'd0);
    check("rmid_async_instr", 64'(instruction), 64'd0);
    check("rmid_async_addr",  64'(mem_read_address), 64'd0);
    #2 rst = 1'b1;
    tick();
    mem_read_ready = 1'b1; mem_read_data = 32'h1234_5678;
    tick();
    mem_read_ready = 1'b0;
    tick();
    check("rmid_late_valid", 64'(mem_read_valid), 64'd0);
    check("rmid_late_instr", 64'(instruction), 64'd0);
    check("rmid_late_state", 64'(fetcher_state), 64'd0);

    // Fetch pc=0x05, then refetch it: a hit with the tag, a request without.
    pc = 8'h05; simd_state = SIMD_FETCH;
    tick();
    check("rf1_state", 64'(fetcher_state), 64'(FETCH_REQ));
    simd_state = SIMD_WAIT;
    mem_read_ready = 1'b1; mem_read_data = 32'h0BAD_F00D; exp_q.push_back(32'h0BAD_F00D);
    tick();
    mem_read_ready = 1'b0;
    check_latch("rf1");
    simd_state = SIMD_DECODE;
    tick();
    simd_state = SIMD_FETCH;
    tick();
`ifdef FETCHER_LAST_HIT_EN
    check("hit_state", 64'(fetcher_state), 64'(FETCH_DONE));
    check("hit_valid", 64'(mem_read_valid), 64'd0);
    check("hit_instr", 64'(instruction), 64'h0BAD_F00D);
`else
    check("nohit_state", 64'(fetcher_state), 64'(FETCH_REQ));
    check("nohit_valid", 64'(mem_read_valid), 64'd1);
    check("nohit_addr",  64'(mem_read_address), 64'h05);
    simd_state = SIMD_WAIT;
    mem_read_ready = 1'b1; exp_q.push_back(32'h0BAD_F00D);
    tick();
    mem_read_ready = 1'b0;
    check_latch("nohit");
`endif
    simd_state = SIMD_DECODE;
    tick();
    pc = 8'h06; simd_state = SIMD_FETCH;
    tick();
    check("miss_state", 64'(fetcher_state), 64'(FETCH_REQ));
    check("miss_valid", 64'(mem_read_valid), 64'd1);
    check("miss_addr",  64'(mem_read_address), 64'h06);
    simd_state = SIMD_WAIT;
    mem_read_ready = 1'b1; mem_read_data = 32'h0000_0066; exp_q.push_back(32'h0000_0066);
    tick();
    mem_read_ready = 1'b0;
    check_latch("miss");
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 SHALL have parameter PROGRAM_ADDR_WIDTH, default 8: program memory address width.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 32: instruction word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port enable  input  1  block is active; when low, state and outputs hold.
REQ-006 SHALL have port simd_state  input  3  core SIMD phase, using the shared SIMD_* encodings.
REQ-007 SHALL have port pc  input  PROGRAM_ADDR_WIDTH  address of the instruction to fetch.
REQ-008 SHALL have port mem_read_valid  output  1  read request to program memory.
REQ-009 SHALL have port mem_read_address  output  PROGRAM_ADDR_WIDTH  request address.
REQ-010 SHALL have port mem_read_ready  input  1  memory response valid; data is on mem_read_data this cycle.
REQ-011 SHALL have port mem_read_data  input  INSTRUCTION_WIDTH  returned instruction word.
REQ-012 SHALL have port fetcher_state  output  3  current FSM state, for the core scheduler.
REQ-013 SHALL have port instruction  output  INSTRUCTION_WIDTH  latched instruction; feeds the decoder.

Function
REQ-014 SHALL implement FSM states FETCH_IDLE=0, FETCH_REQ=1, FETCH_DONE=2, encoded in the shared package.
REQ-015 SHALL, in FETCH_IDLE with enable=1 and simd_state==SIMD_FETCH, register mem_read_valid=1 and mem_read_address=pc, then move to FETCH_REQ.
REQ-016 SHALL hold mem_read_valid high and mem_read_address stable in FETCH_REQ until the first cycle that mem_read_ready=1.
REQ-017 SHALL, on that edge, latch mem_read_data into instruction, drop mem_read_valid the next cycle, and move to FETCH_DONE.
REQ-018 SHALL add one cycle minimum latency from the SIMD_FETCH sample to the request, and one cycle from ready to FETCH_DONE.
REQ-019 SHALL hold instruction stable through FETCH_DONE and FETCH_IDLE until the next successful latch.
REQ-020 SHALL move from FETCH_DONE to FETCH_IDLE when simd_state==SIMD_DECODE.
REQ-021 SHALL ignore mem_read_ready outside FETCH_REQ.
REQ-022 SHALL ignore pc changes while in FETCH_REQ; the address sampled at request time is used.
REQ-023 SHALL freeze the FSM and all outputs while enable=0, including mid-request; mem_read_valid stays asserted if it already was.
REQ-024 SHALL never assert mem_read_valid in FETCH_IDLE or FETCH_DONE.

Reset
REQ-025 SHALL, on rst=0 at any time, asynchronously force FETCH_IDLE, mem_read_valid=0, mem_read_address=0, instruction=0 and fetcher_state=0.
REQ-026 SHALL abandon an outstanding request when reset mid-FETCH_REQ; a late mem_read_ready after release is ignored.
REQ-027 SHALL resume normal operation on the first rising edge after rst returns high.

Configuration
REQ-028 SHALL, with FETCHER_LAST_HIT_EN defined, keep a one-entry tag: the last fetched address plus a valid bit, cleared by reset.
REQ-029 SHALL, with the macro defined, go from FETCH_IDLE directly to FETCH_DONE on SIMD_FETCH when the tag is valid and equals pc, without asserting mem_read_valid and keeping instruction unchanged.
REQ-030 SHALL, with the macro undefined, always issue a memory request and contain no tag storage.

Structure
REQ-031 SHALL take the SIMD_* phase encodings and the FETCH_* state encodings from shared common_defs.
REQ-032 SHALL be a single module; the FETCHER_LAST_HIT_EN tag register stays inline, with no sub-module.

Verification
REQ-033 SHALL verify a basic fetch: pc=0x05, SIMD_FETCH, ready 3 cycles later with data 0x1C0C2000 -> address 0x05 held with valid, instruction=0x1C0C2000, fetcher_state=2.
REQ-034 SHALL verify zero-wait memory: ready high on the first FETCH_REQ cycle -> valid is high exactly one cycle and FETCH_DONE follows.
REQ-035 SHALL verify the return to idle: simd_state=SIMD_DECODE in FETCH_DONE -> fetcher_state=0 the next cycle, instruction unchanged.
REQ-036 SHALL verify reset mid-request: rst=0 during FETCH_REQ, then ready pulse after release -> valid=0, instruction=0, state=0.
REQ-037 SHALL verify stall: enable=0 for 4 cycles in FETCH_REQ with ready=1 -> no latch; the latch happens after enable returns high.
REQ-038 SHALL verify a hit with FETCHER_LAST_HIT_EN: refetch pc=0x05 -> no valid pulse, FETCH_DONE in 1 cycle; then pc=0x06 -> memory request issued.
